rggen_register_access_sequencer: RTL

- Sits directly upstream of the register bank that instantiates rggen_bit_field.
- Accepts one host request at a time over a valid/ready request channel.
- Broadcasts the access to all register slots. Each slot decodes the address and reports a hit, a ready, an error flag and read data.
- Merges the slot responses and returns one response per request over a valid/ready response channel. Decode misses, decode conflicts and a stall timeout are reported as errors.

---
 rtl/rggen_register_access_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rggen_register_access_sequencer.sv
// Single-outstanding host-to-register-bank sequencer: broadcasts one latched access to all
// slots, merges the per-slot hit/ready/error/data and returns a registered response.
module rggen_register_access_sequencer #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned REGISTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
  input  logic                           i_req_write,
  input  logic [BUS_WIDTH-1:0]           i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
  output logic                           o_resp_valid,
  input  logic                           i_resp_ready,
  output logic                           o_resp_error,
  output logic [BUS_WIDTH-1:0]           o_resp_read_data,
  output logic                           o_reg_valid,
  output logic                           o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_mask,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [REGISTERS-1:0]           i_reg_error,
  input  logic [REGISTERS*BUS_WIDTH-1:0] i_reg_read_data
);

  localparam int unsigned STRB_W = BUS_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       write_q, write_d;
  logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
  logic [BUS_WIDTH-1:0]       mask_q, mask_d;
  logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
  logic                       resp_error_q, resp_error_d;
  logic [BUS_WIDTH-1:0]       resp_data_q, resp_data_d;

  logic                       single_hit;
  logic                       sel_ready;
  logic                       sel_error;
  logic [BUS_WIDTH-1:0]       sel_data;
  logic [BUS_WIDTH-1:0]       strobe_mask;
  logic                       timeout_hit;

  // Merge slot responses; only the single active slot contributes.
  always_comb begin
    single_hit = (i_reg_active != '0) &&
                 ((i_reg_active & (i_reg_active - REGISTERS'(1))) == '0);
    sel_ready  = |(i_reg_active & i_reg_ready);
    sel_error  = |(i_reg_active & i_reg_error);
    sel_data   = '0;
    for (int unsigned k = 0; k < REGISTERS; k++) begin
      if (i_reg_active[k]) begin
        sel_data = sel_data | i_reg_read_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    strobe_mask = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      strobe_mask[8*i +: 8] = {8{i_req_strobe[i]}};
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    address_d    = address_q;
    mask_d       = mask_q;
    write_data_d = write_data_q;
    resp_error_d = resp_error_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          write_d      = i_req_write;
          address_d    = i_req_address;
          write_data_d = i_req_write_data;
          // Reads get a full mask so read-side-effect fields always fire.
          mask_d       = i_req_write ? strobe_mask : '1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!single_hit) begin
          resp_error_d = 1'b1;
          resp_data_d  = '0;
          cnt_d        = '0;
          state_d      = RESPONSE;
        end else if (sel_ready) begin
          resp_error_d = sel_error;
          resp_data_d  = (write_q || sel_error) ? '0 : sel_data;
          cnt_d        = '0;
          state_d      = RESPONSE;
        end else if (timeout_hit) begin
          resp_error_d = 1'b1;
          resp_data_d  = '0;
          cnt_d        = '0;
          state_d      = RESPONSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPONSE: begin
        if (i_resp_ready) begin
          resp_error_d = 1'b0;
          resp_data_d  = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      mask_q       <= '0;
      write_data_q <= '0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      address_q    <= address_d;
      mask_q       <= mask_d;
      write_data_q <= write_data_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // o_reg_valid is the one output allowed to follow i_reg_active combinationally.
  assign o_req_ready      = (state_q == IDLE);
  assign o_resp_valid     = (state_q == RESPONSE);
  assign o_reg_valid      = (state_q == ACCESS) && single_hit;
  assign o_reg_write      = write_q;
  assign o_reg_address    = address_q;
  assign o_reg_mask       = mask_q;
  assign o_reg_write_data = write_data_q;
  assign o_resp_error     = resp_error_q;
  assign o_resp_read_data = resp_data_q;

endmodule
